// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Purpose:
//   Sits between the memory stage of the core and a slower backing data
//   memory. Stores are queued in a small circular FIFO and drained in order
//   over a req/ack handshake. Loads read the backing memory combinationally.
//
// Optional feature (macro STORE_BUF_FWD_EN):
//   defined   - a load returns the data of the youngest pending store to the
//               same word; loads never stall.
//   undefined - a load always returns bus_rdata; instead, the core is stalled
//               while it loads a word that still has pending stores.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset; clears all state
//   mem_write   store request from the memory stage
//   mem_read    load request from the memory stage
//   mem_addr    byte address (word aligned, bits [1:0] ignored)
//   write_data  store data
//   read_data   load data (combinational)
//   stall       core must hold its memory stage this cycle
//   empty       no pending stores
//   count       number of pending entries
//   overflow    sticky: a store was dropped because the buffer was full
//   bus_req     drain request to backing memory
//   bus_addr    drain address (head entry)
//   bus_wdata   drain data (head entry)
//   bus_ack     backing memory accepted the head entry this cycle
//   bus_raddr   combinational read address (= mem_addr)
//   bus_rdata   combinational read data from backing memory
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_write,
    input  logic                mem_read,
    input  logic [WIDTH-1:0]    mem_addr,
    input  logic [WIDTH-1:0]    write_data,
    output logic [WIDTH-1:0]    read_data,
    output logic                stall,
    output logic                empty,
    output logic [PTR_BITS:0]   count,
    output logic                overflow,
    output logic                bus_req,
    output logic [WIDTH-1:0]    bus_addr,
    output logic [WIDTH-1:0]    bus_wdata,
    input  logic                bus_ack,
    output logic [WIDTH-1:0]    bus_raddr,
    input  logic [WIDTH-1:0]    bus_rdata
);

    localparam int AW = WIDTH - 2;
    localparam int CW = PTR_BITS + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PTR_BITS-1:0]    r_head;
    logic [PTR_BITS-1:0]    r_tail;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_next;
    logic                   r_overflow;

    // Entry storage: word address (byte offset dropped) and data.
    logic [AW-1:0]          r_addr_mem [DEPTH];
    logic [WIDTH-1:0]       r_data_mem [DEPTH];

    logic                   w_pop;
    logic                   w_push;
    logic                   w_hit;
    logic [DEPTH-1:0]       w_match;    // indexed by age: 0 = oldest (head)

    assign w_pop  = bus_req & bus_ack;
    // A store to a full buffer still fits when the head retires this cycle.
    assign w_push = mem_write & ((r_count < FULL_CNT) | w_pop);

    // -----------------------------------------------------------------------
    // Per-slot address compare. Validity is derived from the slot's age
    // relative to head, so no per-entry valid bits need clearing on reset.
    // -----------------------------------------------------------------------
`ifdef STORE_BUF_FWD_EN
    logic [WIDTH-1:0]       w_slot_data [DEPTH];
    logic [WIDTH-1:0]       w_fwd_data;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_BITS-1:0] w_idx;
            assign w_idx        = r_head + PTR_BITS'(gi);
            assign w_match[gi]  = (r_count > CW'(gi)) &&
                                  (r_addr_mem[w_idx] == mem_addr[WIDTH-1:2]);
`ifdef STORE_BUF_FWD_EN
            assign w_slot_data[gi] = r_data_mem[w_idx];
`endif
        end
    endgenerate

    assign w_hit = |w_match;

`ifdef STORE_BUF_FWD_EN
    // Later (younger) matches override earlier ones.
    always_comb begin
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[k]) begin
                w_fwd_data = w_slot_data[k];
            end
        end
    end

    assign read_data = w_hit ? w_fwd_data : bus_rdata;
    assign stall     = (r_count == FULL_CNT) & ~w_pop;
`else
    assign read_data = bus_rdata;
    // A load to a word with pending stores waits until they have drained.
    assign stall     = ((r_count == FULL_CNT) & ~w_pop) | (mem_read & w_hit);
`endif

    // -----------------------------------------------------------------------
    // Storage write (no reset needed: contents are qualified by count).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= mem_addr[WIDTH-1:2];
            r_data_mem[r_tail] <= write_data;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_BITS'(1);
            end
            r_count <= w_count_next;
            if (mem_write && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Drain FSM. Decisions use the post-edge count so a store into an empty
    // buffer is requested in the very next cycle and back-to-back drains
    // need no idle cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_count_next != '0) w_state_next = S_REQ;
            S_REQ:  if (w_pop && (w_count_next == '0)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus_req = 1'b0;
        case (r_state)
            S_REQ:   bus_req = 1'b1;
            default: bus_req = 1'b0;
        endcase
    end

    assign bus_addr  = {r_addr_mem[r_head], 2'b00};
    assign bus_wdata = r_data_mem[r_head];
    assign bus_raddr = mem_addr;
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign overflow  = r_overflow;

endmodule
